// File: rtl/cpu_pipe_pkg.sv
// Shared types for the LEGv8 pipeline hazard/forwarding logic: operand select
// encoding, the shadow-pipeline entry record and the register dependency test.
package cpu_pipe_pkg;

    localparam int PIPE_REG_W = 5;
    localparam logic [PIPE_REG_W-1:0] XZR = 5'd31;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic                  valid;
        logic [PIPE_REG_W-1:0] rn;
        logic [PIPE_REG_W-1:0] rb;
        logic                  use_a;
        logic                  use_b;
        logic [PIPE_REG_W-1:0] rd;
        logic                  reg_write;
        logic                  is_load;
        logic                  set_flag;
        logic                  use_flags;
    } pipe_entry_t;

    // True when entry e will write register r; the zero register never carries a value.
    function automatic logic dep(input pipe_entry_t e,
                                 input logic [PIPE_REG_W-1:0] r,
                                 input logic [PIPE_REG_W-1:0] zero_reg);
        return e.valid & e.reg_write & (e.rd == r) & (r != zero_reg);
    endfunction

endpackage

// File: rtl/fwd_sel_unit.sv
// Operand forwarding select for one EX source operand: EX/MEM has priority over
// MEM/WB, and a load still in MEM is never a forwarding source.
module fwd_sel_unit
    import cpu_pipe_pkg::*;
#(
    parameter int                    FWD_EN   = 1,
    parameter logic [PIPE_REG_W-1:0] ZERO_REG = XZR
) (
    input  logic                  use_i,
    input  logic [PIPE_REG_W-1:0] reg_i,
    input  pipe_entry_t           mem_i,
    input  pipe_entry_t           wb_i,
    output fwd_sel_t              sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (FWD_EN != 0 && use_i) begin
            if (dep(mem_i, reg_i, ZERO_REG) && !mem_i.is_load) begin
                sel_o = FWD_EXMEM;
            end else if (dep(wb_i, reg_i, ZERO_REG)) begin
                sel_o = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage LEGv8 pipeline. Tracks the
// EX/MEM/WB occupants in a shadow record and derives stalls, flushes and selects.
module pipe_hazard_ctrl
    import cpu_pipe_pkg::*;
#(
    parameter int               REG_W  = 5,
    parameter logic [REG_W-1:0] XZR    = cpu_pipe_pkg::XZR,
    parameter int               FWD_EN = 1,
    parameter int               CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rb,
    input  logic             id_use_a,
    input  logic             id_use_b,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_is_load,
    input  logic             id_set_flag,
    input  logic             id_use_flags,
    input  logic             br_redirect,
    output logic             pc_write_en,
    output logic             ifid_write_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             flag_fwd,
    output logic [CNT_W-1:0] stall_cnt
);

    pipe_entry_t      ex_q, mem_q, wb_q;
    pipe_entry_t      ex_d, id_entry;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             rd_a, rd_b;
    logic             hazard, stall, redirect;
    fwd_sel_t         sel_a, sel_b;

    assign rd_a = id_valid & id_use_a;
    assign rd_b = id_valid & id_use_b;

    always_comb begin
        hazard = 1'b0;
        if (FWD_EN != 0) begin
            // Only a load one stage ahead is unreachable by forwarding.
            hazard = ex_q.is_load &
                     ((rd_a & dep(ex_q, id_rn, XZR)) | (rd_b & dep(ex_q, id_rb, XZR)));
        end else begin
            // Regfile writes early in the cycle but is still treated as busy during WB.
            hazard = (rd_a & (dep(ex_q, id_rn, XZR) | dep(mem_q, id_rn, XZR) |
                              dep(wb_q, id_rn, XZR))) |
                     (rd_b & (dep(ex_q, id_rb, XZR) | dep(mem_q, id_rb, XZR) |
                              dep(wb_q, id_rb, XZR))) |
                     (id_valid & id_use_flags &
                      ((ex_q.valid & ex_q.set_flag) | (mem_q.valid & mem_q.set_flag)));
        end
    end

    // A redirect squashes the stalled instruction anyway, so it wins over any stall.
    assign redirect = br_redirect & ~reset;
    assign stall    = hazard & ~redirect;

    assign pc_write_en   = ~stall;
    assign ifid_write_en = ~stall;
    assign ifid_flush    = redirect;
    assign idex_bubble   = stall | redirect;
    assign flag_fwd      = ex_q.valid & ex_q.use_flags & mem_q.valid & mem_q.set_flag;
    assign stall_cnt     = stall_cnt_q;

    fwd_sel_unit #(.FWD_EN(FWD_EN), .ZERO_REG(XZR)) u_fwd_a (
        .use_i (ex_q.valid & ex_q.use_a),
        .reg_i (ex_q.rn),
        .mem_i (mem_q),
        .wb_i  (wb_q),
        .sel_o (sel_a)
    );

    fwd_sel_unit #(.FWD_EN(FWD_EN), .ZERO_REG(XZR)) u_fwd_b (
        .use_i (ex_q.valid & ex_q.use_b),
        .reg_i (ex_q.rb),
        .mem_i (mem_q),
        .wb_i  (wb_q),
        .sel_o (sel_b)
    );

    assign fwd_a = sel_a;
    assign fwd_b = sel_b;

    always_comb begin
        id_entry = '{valid:     id_valid,
                     rn:        id_rn,
                     rb:        id_rb,
                     use_a:     id_use_a,
                     use_b:     id_use_b,
                     rd:        id_rd,
                     reg_write: id_reg_write,
                     is_load:   id_is_load,
                     set_flag:  id_set_flag,
                     use_flags: id_use_flags};
        ex_d = (id_valid && !idex_bubble) ? id_entry : '0;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_write_en && stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= ex_q;
            wb_q        <= mem_q;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
